// File: rtl/alu.sv
// Purpose     : single-cycle registered ALU (logic, add/sub, signed set-less-than).
// Latency     : one clk; operands sampled at edge N are visible on aluRslt/zero after edge N.
// Backpressure: none; no handshake, a new operation is accepted on every clk edge.
//
// Ports:
//   clk       rising-edge clock for all state
//   reset     synchronous, active-high; forces aluRslt=0, zero=1, overflow=0
//   srcA      operand A (two's complement where signed)
//   srcB      operand B (two's complement where signed)
//   aluCtrl   operation select:
//               000 A&B   001 A|B   010 A+B   011 A^B
//               100 A&~B  101 A|~B  110 A-B   111 SLT (signed)
//   aluRslt   registered result
//   zero      registered flag, 1 when the registered aluRslt is 0
//   overflow  registered signed-overflow flag for add/sub
//             (port exists only when ALU_OVERFLOW_EN is defined)
//
// Build option: define ALU_OVERFLOW_EN to add the overflow port and its logic.

module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [2:0]       aluCtrl,
    output logic [WIDTH-1:0] aluRslt,
    output logic             zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    localparam int MSB = WIDTH - 1;

    // aluCtrl[2] selects the inverted B operand for every upper-half op:
    // AND-NOT, OR-NOT, and the subtractor used by SUB and SLT. The same bit
    // doubles as the adder carry-in so A + ~B + 1 falls out of one adder.
    logic             invertB;
    logic [WIDTH-1:0] srcBMux;
    logic [WIDTH-1:0] carryIn;
    logic [WIDTH-1:0] adderSum;

    assign invertB  = aluCtrl[2];
    assign srcBMux  = invertB ? ~srcB : srcB;
    assign carryIn  = {{(WIDTH-1){1'b0}}, invertB};
    // Modulo 2^WIDTH: carry-out is intentionally not kept.
    assign adderSum = srcA + srcBMux + carryIn;

    // Signed overflow of the adder as actually configured: the two adder
    // inputs share a sign and the sum sign differs. Because srcBMux already
    // carries ~B for subtraction, this single expression covers both
    // "same signs on add" and "different signs on sub".
    logic adderOvf;
    assign adderOvf = (srcA[MSB] == srcBMux[MSB]) && (adderSum[MSB] != srcA[MSB]);

    // Signed A < B from the A-B subtraction. The raw sign bit is wrong when
    // the subtraction overflows (e.g. 0x80000000 - 1), so correct it with the
    // overflow bit.
    logic sltLess;
    assign sltLess = adderSum[MSB] ^ adderOvf;

    // Next-state result; every encoding is listed so no path yields X.
    logic [WIDTH-1:0] rsltNext;
    always_comb begin
        rsltNext = '0;
        case (aluCtrl)
            OP_AND:  rsltNext = srcA & srcB;
            OP_OR:   rsltNext = srcA | srcB;
            OP_ADD:  rsltNext = adderSum;
            OP_XOR:  rsltNext = srcA ^ srcB;
            OP_ANDN: rsltNext = srcA & srcBMux;
            OP_ORN:  rsltNext = srcA | srcBMux;
            OP_SUB:  rsltNext = adderSum;
            OP_SLT:  rsltNext = {{(WIDTH-1){1'b0}}, sltLess};
        endcase
    end

    // zero is computed from the same combinational value that is registered
    // into aluRslt, so the two outputs can never disagree.
    logic zeroNext;
    assign zeroNext = (rsltNext == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            aluRslt <= '0;
            zero    <= 1'b1;
        end else begin
            aluRslt <= rsltNext;
            zero    <= zeroNext;
        end
    end

`ifdef ALU_OVERFLOW_EN
    // Only ADD and SUB report overflow; SLT uses the subtractor internally
    // but its result cannot overflow, so the flag stays low there.
    logic ovfNext;
    assign ovfNext = ((aluCtrl == OP_ADD) || (aluCtrl == OP_SUB)) && adderOvf;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= ovfNext;
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (WIDTH=32).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Overflow checks are compiled in with ALU_OVERFLOW_EN.

module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [2:0]  aluCtrl;
    logic [31:0] aluRslt;
    logic        zero;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int checks;
    int errors;

    alu #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .srcA     (srcA),
        .srcB     (srcB),
        .aluCtrl  (aluCtrl),
        .aluRslt  (aluRslt),
        .zero     (zero)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        @(negedge clk);
        reset   = 1'b1;
        srcA    = 32'd5;
        srcB    = 32'd3;
        aluCtrl = 3'b010;
        @(posedge clk);
        #1;
        checks++;
        if (aluRslt !== 32'h0) begin
            errors++;
            $display("FAIL reset_rslt: got %h expected %h", aluRslt, 32'h0);
        end
        checks++;
        if (zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_zero: got %b expected 1", zero);
        end
`ifdef ALU_OVERFLOW_EN
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b expected 0", overflow);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_logic();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [2:0]  vc [6];
        logic [31:0] vr [6];
        logic        expZ;
        va = '{32'h0, 32'h1, 32'h3, 32'h5,        32'hFF00FF00, 32'hF0F0F0F0};
        vb = '{32'h0, 32'h1, 32'h3, 32'hFFFFFFFF, 32'h0FF00FF0, 32'h0F0F0F0F};
        vc = '{3'b000, 3'b001, 3'b011, 3'b100,    3'b000,       3'b101};
        vr = '{32'h0, 32'h1, 32'h0, 32'h0,        32'h0F000F00, 32'hF0F0F0F0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            srcA = va[i]; srcB = vb[i]; aluCtrl = vc[i];
            @(posedge clk);
            #1;
            expZ = (vr[i] == 32'h0);
            checks++;
            if (aluRslt !== vr[i]) begin
                errors++;
                $display("FAIL logic_rslt[%0d]: got %h expected %h", i, aluRslt, vr[i]);
            end
            checks++;
            if (zero !== expZ) begin
                errors++;
                $display("FAIL logic_zero[%0d]: got %b expected %b", i, zero, expZ);
            end
        end
    endtask

    task automatic test_arith();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [2:0]  vc [7];
        logic [31:0] vr [7];
        logic        expZ;
`ifdef ALU_OVERFLOW_EN
        logic        vo [7];
        vo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
        va = '{32'h2,   32'hFFFFFFFF, 32'h0,   32'h9,   32'h7FFFFFFF, 32'h80000000, 32'h7};
        vb = '{32'h2,   32'h1,        32'h1,   32'h4,   32'h1,        32'h1,        32'h7};
        vc = '{3'b010,  3'b010,       3'b110,  3'b110,  3'b010,       3'b110,       3'b110};
        vr = '{32'h4,   32'h0,        32'hFFFFFFFF, 32'h5, 32'h80000000, 32'h7FFFFFFF, 32'h0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            srcA = va[i]; srcB = vb[i]; aluCtrl = vc[i];
            @(posedge clk);
            #1;
            expZ = (vr[i] == 32'h0);
            checks++;
            if (aluRslt !== vr[i]) begin
                errors++;
                $display("FAIL arith_rslt[%0d]: got %h expected %h", i, aluRslt, vr[i]);
            end
            checks++;
            if (zero !== expZ) begin
                errors++;
                $display("FAIL arith_zero[%0d]: got %b expected %b", i, zero, expZ);
            end
`ifdef ALU_OVERFLOW_EN
            checks++;
            if (overflow !== vo[i]) begin
                errors++;
                $display("FAIL arith_ovf[%0d]: got %b expected %b", i, overflow, vo[i]);
            end
`endif
        end
    endtask

    task automatic test_slt();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] vr [7];
        logic        expZ;
        va = '{32'h4, 32'hFFFFFFFF, 32'h80000000, 32'h1,        32'h7FFFFFFF, 32'h3, 32'h5};
        vb = '{32'h4, 32'h1,        32'h1,        32'h80000000, 32'h80000000, 32'h5, 32'h3};
        vr = '{32'h0, 32'h1,        32'h1,        32'h0,        32'h0,        32'h1, 32'h0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            srcA = va[i]; srcB = vb[i]; aluCtrl = 3'b111;
            @(posedge clk);
            #1;
            expZ = (vr[i] == 32'h0);
            checks++;
            if (aluRslt !== vr[i]) begin
                errors++;
                $display("FAIL slt_rslt[%0d]: got %h expected %h", i, aluRslt, vr[i]);
            end
            checks++;
            if (zero !== expZ) begin
                errors++;
                $display("FAIL slt_zero[%0d]: got %b expected %b", i, zero, expZ);
            end
`ifdef ALU_OVERFLOW_EN
            checks++;
            if (overflow !== 1'b0) begin
                errors++;
                $display("FAIL slt_ovf[%0d]: got %b expected 0", i, overflow);
            end
`endif
        end
    endtask

    // Outputs must hold between edges even when inputs change.
    task automatic test_hold();
        @(negedge clk);
        srcA = 32'h12345678; srcB = 32'h11111111; aluCtrl = 3'b010;
        @(posedge clk);
        #1;
        checks++;
        if (aluRslt !== 32'h23456789) begin
            errors++;
            $display("FAIL hold_first: got %h expected %h", aluRslt, 32'h23456789);
        end
        srcA = 32'h0; srcB = 32'h0; aluCtrl = 3'b000;
        #3;
        checks++;
        if (aluRslt !== 32'h23456789) begin
            errors++;
            $display("FAIL hold_mid_cycle: got %h expected %h", aluRslt, 32'h23456789);
        end
        checks++;
        if (zero !== 1'b0) begin
            errors++;
            $display("FAIL hold_zero: got %b expected 0", zero);
        end
    endtask

    // One op per cycle; just after each new input the output must still show
    // the previous result, and right after the edge it must show the new one.
    task automatic test_back_to_back();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [2:0]  vc [5];
        logic [31:0] vr [5];
        logic [31:0] prev;
        va = '{32'h10, 32'hAAAA0000, 32'h8, 32'h6, 32'h0000FFFF};
        vb = '{32'h20, 32'h5555FFFF, 32'h3, 32'h6, 32'h0000FF00};
        vc = '{3'b010, 3'b001,       3'b110, 3'b011, 3'b100};
        vr = '{32'h30, 32'hFFFFFFFF, 32'h5, 32'h0,  32'h000000FF};
        prev = aluRslt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            srcA = va[i]; srcB = vb[i]; aluCtrl = vc[i];
            #1;
            checks++;
            if (aluRslt !== prev) begin
                errors++;
                $display("FAIL b2b_prelatch[%0d]: got %h expected %h", i, aluRslt, prev);
            end
            @(posedge clk);
            #1;
            checks++;
            if (aluRslt !== vr[i]) begin
                errors++;
                $display("FAIL b2b_rslt[%0d]: got %h expected %h", i, aluRslt, vr[i]);
            end
            prev = vr[i];
        end
        // Reset mid-stream with a non-zero op pending.
        @(negedge clk);
        reset = 1'b1;
        srcA = 32'h40; srcB = 32'h2; aluCtrl = 3'b010;
        @(posedge clk);
        #1;
        checks++;
        if (aluRslt !== 32'h0) begin
            errors++;
            $display("FAIL b2b_reset_rslt: got %h expected %h", aluRslt, 32'h0);
        end
        checks++;
        if (zero !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reset_zero: got %b expected 1", zero);
        end
        // First edge with reset low takes the inputs present at that edge.
        @(negedge clk);
        reset = 1'b0;
        srcA = 32'h9; srcB = 32'h1; aluCtrl = 3'b110;
        @(posedge clk);
        #1;
        checks++;
        if (aluRslt !== 32'h8) begin
            errors++;
            $display("FAIL b2b_release_rslt: got %h expected %h", aluRslt, 32'h8);
        end
        checks++;
        if (zero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release_zero: got %b expected 0", zero);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        srcA    = 32'h0;
        srcB    = 32'h0;
        aluCtrl = 3'b000;

        test_reset();
        test_logic();
        test_arith();
        test_slt();
        test_hold();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; all requirements below use WIDTH=32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 srcA  input  WIDTH  operand A, two's complement where signed.
REQ-005 srcB  input  WIDTH  operand B, two's complement where signed.
REQ-006 aluCtrl  input  3  operation select.
REQ-007 aluRslt  output  WIDTH  registered result.
REQ-008 zero  output  1  registered flag, 1 when the registered aluRslt equals 0.
REQ-009 overflow  output  1  registered signed-overflow flag; present only when ALU_OVERFLOW_EN is defined.

Function
REQ-010 Operations by aluCtrl: 000 A AND B; 001 A OR B; 010 A+B; 011 A XOR B; 100 A AND NOT B; 101 A OR NOT B; 110 A-B; 111 SLT (signed).
REQ-011 Add/sub: modulo 2^WIDTH; carry-out discarded; subtraction computed as A + ~B + 1.
REQ-012 SLT: result 32'h00000001 when signed(A) < signed(B), else 0; comparison correct when A-B overflows (e.g. A=0x80000000, B=1 -> 1).
REQ-013 Latency: exactly one cycle; operands and aluCtrl sampled at rising edge N appear on aluRslt/zero after edge N; outputs hold until next edge.
REQ-014 No handshake; a new operation is accepted every cycle.
REQ-015 zero derived from the same combinational result registered into aluRslt, so zero and aluRslt are always consistent in the same cycle.
REQ-016 X/undefined aluCtrl is not a case; all 8 encodings are defined, no default-to-X path.
REQ-017 Outputs depend only on values sampled at the edge; input changes between edges do not affect outputs.

Reset
REQ-018 When reset=1 at a rising edge: aluRslt=0, zero=1, overflow=0 (if present); reset overrides any operation that edge.
REQ-019 Reset asserted mid-stream discards the in-flight operation; first result after release reflects inputs sampled at the first edge with reset=0.
REQ-020 Before the first reset edge outputs are unspecified; benches shall apply reset first.

Configuration
REQ-021 Macro ALU_OVERFLOW_EN: when defined, port overflow exists and is registered with the result: 1 for aluCtrl=010 when operands share a sign and the sum sign differs; 1 for aluCtrl=110 when operand signs differ and the difference sign differs from A; 0 for all other codes (including 111).
REQ-022 When ALU_OVERFLOW_EN is undefined, port overflow and its logic are absent; all other behaviour is identical.

Verification
REQ-023 reset=1 one edge -> aluRslt=0, zero=1, overflow=0.
REQ-024 A=0,B=0,ctrl=000 -> next cycle aluRslt=0, zero=1; A=1,B=1,ctrl=001 -> aluRslt=1, zero=0.
REQ-025 A=2,B=2,ctrl=010 -> aluRslt=4, zero=0; A=3,B=3,ctrl=011 -> aluRslt=0, zero=1.
REQ-026 A=4,B=4,ctrl=111 -> aluRslt=0, zero=1; A=0xFFFFFFFF,B=1,ctrl=111 -> aluRslt=1; A=5,B=0xFFFFFFFF,ctrl=100 -> aluRslt=0, zero=1.
REQ-027 With ALU_OVERFLOW_EN: A=0x7FFFFFFF,B=1,ctrl=010 -> aluRslt=0x80000000, overflow=1; A=0x80000000,B=1,ctrl=110 -> aluRslt=0x7FFFFFFF, overflow=1; A=7,B=7,ctrl=110 -> aluRslt=0, zero=1, overflow=0.
REQ-028 Back-to-back ops each cycle then reset asserted mid-sequence -> each result appears exactly one cycle after its inputs; reset edge forces aluRslt=0, zero=1 regardless of pending inputs.
